// File: rtl/sprite_raster_gen_if.sv
// Pixel-stream bundle between the raster generator and the sim harness / SDL sink.
// master: raster generator (buttons in, pixel stream out); slave: harness/sink side.
interface sprite_raster_gen_if;
  logic       btn_up;
  logic       btn_dn;
  logic       btn_fire;
  logic [9:0] sdl_sx;
  logic [9:0] sdl_sy;
  logic       sdl_de;
  logic [7:0] sdl_r;
  logic [7:0] sdl_g;
  logic [7:0] sdl_b;
  logic       frame_tick;

  modport master (
    input  btn_up, btn_dn, btn_fire,
    output sdl_sx, sdl_sy, sdl_de, sdl_r, sdl_g, sdl_b, frame_tick
  );

  modport slave (
    output btn_up, btn_dn, btn_fire,
    input  sdl_sx, sdl_sy, sdl_de, sdl_r, sdl_g, sdl_b, frame_tick
  );
endinterface

// File: rtl/sprite_raster_gen.sv
// Full-frame raster scan (active + blanking) with one button-driven square sprite
// and a fire-flash/cooldown FSM. Sprite state changes only on frame_tick, which
// falls in vertical blanking, so a frame is never drawn with mixed state.
// Optional macro SPRITE_BORDER_EN: white 1-pixel border around the active area.
module sprite_raster_gen #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_TOTAL      = 800,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_TOTAL      = 525,
  parameter int          SPR_SIZE     = 10,
  parameter int          SPR_STEP     = 2,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [23:0] SPR_RGB      = 24'h0000FF,
  parameter logic [23:0] BG_RGB       = 24'h000000
) (
  input  logic                       clk_pix,
  input  logic                       sim_rst,
  sprite_raster_gen_if.master        bus
);

  localparam logic [9:0]  HT_M1  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VT_M1  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HA     = 10'(H_ACTIVE);
  localparam logic [9:0]  VA     = 10'(V_ACTIVE);
  localparam logic [9:0]  VA_M1  = 10'(V_ACTIVE - 1);
  localparam logic [10:0] SPR_X  = 11'((H_ACTIVE - SPR_SIZE) / 2);
  localparam logic [9:0]  SPR_Y0 = 10'((V_ACTIVE - SPR_SIZE) / 2);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - SPR_SIZE);
  localparam logic [10:0] STEP   = 11'(SPR_STEP);
  localparam logic [10:0] SIZE   = 11'(SPR_SIZE);
  localparam logic [15:0] FC_TOP = 16'(FLASH_FRAMES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLASH = 2'd1;
  localparam logic [1:0] S_COOL  = 2'd2;

  logic [9:0]  r_sx, r_sy, r_spr_y;
  logic        r_tick;
  logic [2:0]  r_btn_s1, r_btn_s2;   // {fire, dn, up}
  logic [1:0]  r_state;
  logic [15:0] r_fcnt;

  logic        w_up, w_dn, w_fire;
  logic [10:0] w_y_ext, w_y_up, w_y_dn_raw, w_y_dn, w_sx_ext, w_sy_ext;
  logic        w_de, w_hit, w_border;
  logic [23:0] w_spr_rgb, w_rgb;

  assign w_up   = r_btn_s2[0];
  assign w_dn   = r_btn_s2[1];
  assign w_fire = r_btn_s2[2];

  // 11-bit extended clamp arithmetic: the up path saturates at 0, the down path at Y_MAX
  assign w_y_ext    = {1'b0, r_spr_y};
  assign w_y_up     = (w_y_ext < STEP) ? 11'd0 : (w_y_ext - STEP);
  assign w_y_dn_raw = w_y_ext + STEP;
  assign w_y_dn     = (w_y_dn_raw > Y_MAX) ? Y_MAX : w_y_dn_raw;

  assign w_sx_ext = {1'b0, r_sx};
  assign w_sy_ext = {1'b0, r_sy};
  assign w_de     = (r_sx < HA) && (r_sy < VA);
  assign w_hit    = (w_sx_ext >= SPR_X) && (w_sx_ext < SPR_X + SIZE) &&
                    (w_sy_ext >= w_y_ext) && (w_sy_ext < w_y_ext + SIZE);
  assign w_spr_rgb = (r_state == S_FLASH) ? 24'hFFFFFF : SPR_RGB;

`ifdef SPRITE_BORDER_EN
  assign w_border = (r_sx == 10'd0) || (r_sx == HA - 10'd1) ||
                    (r_sy == 10'd0) || (r_sy == VA_M1);
`else
  assign w_border = 1'b0;
`endif

  // Raster counters; frame_tick is registered so it lands exactly on (0, V_ACTIVE)
  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_sx == HT_M1) && (r_sy == VA_M1);
      if (r_sx == HT_M1) begin
        r_sx <= '0;
        r_sy <= (r_sy == VT_M1) ? 10'd0 : r_sy + 10'd1;
      end else begin
        r_sx <= r_sx + 10'd1;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous button levels
  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_btn_s1 <= {bus.btn_fire, bus.btn_dn, bus.btn_up};
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Sprite position: one step per frame tick; opposing buttons cancel
  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      r_spr_y <= SPR_Y0;
    end else if (r_tick) begin
      if (w_up && !w_dn)      r_spr_y <= w_y_up[9:0];
      else if (w_dn && !w_up) r_spr_y <= w_y_dn[9:0];
    end
  end

  // Fire FSM: flash for FLASH_FRAMES ticks, then an equal cooldown that ignores fire
  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      r_state <= S_IDLE;
      r_fcnt  <= '0;
    end else if (r_tick) begin
      case (r_state)
        S_IDLE: if (w_fire) begin
          r_state <= S_FLASH;
          r_fcnt  <= FC_TOP;
        end
        S_FLASH: if (r_fcnt == 16'd0) begin
          r_state <= S_COOL;
          r_fcnt  <= FC_TOP;
        end else begin
          r_fcnt  <= r_fcnt - 16'd1;
        end
        S_COOL: if (r_fcnt == 16'd0) r_state <= S_IDLE;
                else                 r_fcnt  <= r_fcnt - 16'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pixel priority: blanking black, then border, then sprite, then background
  always_comb begin
    w_rgb = 24'h000000;
    if (w_de) begin
      if (w_border)   w_rgb = 24'hFFFFFF;
      else if (w_hit) w_rgb = w_spr_rgb;
      else            w_rgb = BG_RGB;
    end
  end

  assign bus.sdl_sx     = r_sx;
  assign bus.sdl_sy     = r_sy;
  assign bus.sdl_de     = w_de;
  assign bus.sdl_r      = w_rgb[23:16];
  assign bus.sdl_g      = w_rgb[15:8];
  assign bus.sdl_b      = w_rgb[7:0];
  assign bus.frame_tick = r_tick;

endmodule
